// File: rtl/utopia1_phy_tx_pkg.sv
// Shared Utopia cell constants and the byte-serial HEC CRC-8 step.
package utopia_pkg;
  localparam int         CELL_BYTES = 53;
  localparam logic [7:0] HEC_POLY   = 8'h07;
  localparam logic [7:0] HEC_COSET  = 8'h55;

  typedef logic [5:0] off_t;
  localparam off_t LAST_OFF = 6'd52;
  localparam off_t HEC_OFF  = 6'd4;

  typedef enum logic [1:0] {IDLE, SEND, PAUSE} rd_state_e;

  // MSB-first CRC-8 over one byte
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] b);
    logic [7:0] c;
    c = crc ^ b;
    for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ HEC_POLY) : (c << 1);
    return c;
  endfunction
endpackage

// File: rtl/utopia1_phy_tx_if.sv
// Source byte stream plus Utopia L1 cell-level handshake toward the ATM layer.
interface utopia1_phy_tx_if;
  logic [7:0] in_data;
  logic       in_soc;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] data;
  logic       soc;
  logic       en;
  logic       clav;

  modport master (input  in_data, in_soc, in_valid, en,
                  output in_ready, data, soc, clav);
  modport slave  (output in_data, in_soc, in_valid, en,
                  input  in_ready, data, soc, clav);
endinterface

// File: rtl/utopia1_phy_tx_hec_gen.sv
// Byte-serial CRC-8 accumulator; clr together with step restarts on the given byte.
module utopia_hec_gen
  import utopia_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       step,
  input  logic [7:0] byte_in,
  output logic [7:0] value
);
  always_ff @(posedge clk) begin
    if (rst)       value <= 8'h00;
    else if (step) value <= crc8_step(clr ? 8'h00 : value, byte_in);
    else if (clr)  value <= 8'h00;
  end
endmodule

// File: rtl/utopia1_phy_tx.sv
// Utopia L1 PHY cell source: buffers DEPTH cells from a byte stream and plays them out under en.
module utopia1_phy_tx
  import utopia_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter bit GEN_HEC = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  utopia1_phy_tx_if.master             bus,
  output logic [$clog2(DEPTH+1)-1:0]   cell_cnt,
  output logic [7:0]                   drop_cnt
);
  localparam int CNT_W  = $clog2(DEPTH+1);
  localparam int MEM_N  = DEPTH * CELL_BYTES;
  localparam int ADDR_W = $clog2(MEM_N);
  typedef logic [ADDR_W-1:0] addr_t;
  localparam addr_t            STRIDE    = addr_t'(CELL_BYTES);
  localparam addr_t            LAST_BASE = addr_t'((DEPTH-1) * CELL_BYTES);
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  // Slots are tracked by base address so no slot*53 multiply is needed.
  function automatic addr_t next_base(input addr_t b);
    return (b == LAST_BASE) ? '0 : b + STRIDE;
  endfunction

  logic [7:0] mem [MEM_N];

  off_t       wr_off, wr_off_nxt, rd_off, rd_off_nxt;
  addr_t      wr_base, wr_base_nxt, rd_base, rd_base_nxt;
  addr_t      wr_addr, rd_addr;
  logic [7:0] wr_byte, data_q, hec;
  logic       acc, wr_en, wr_done, drop_inc, hec_clr, hec_step;
  logic       rd_load, rd_rel, soc_q, soc_nxt, clav_q, in_ready_q;
  logic [CNT_W-1:0] cnt_nxt;
  rd_state_e  state, state_nxt;

  assign bus.in_ready = in_ready_q;
  assign bus.data     = data_q;
  assign bus.soc      = soc_q;
  assign bus.clav     = clav_q;

  utopia_hec_gen u_hec (
    .clk     (clk),
    .rst     (rst),
    .clr     (hec_clr),
    .step    (hec_step),
    .byte_in (bus.in_data),
    .value   (hec)
  );

  // Write side: framing, HEC insertion, slot completion
  always_comb begin
    acc         = bus.in_valid && in_ready_q;
    wr_en       = 1'b0;
    wr_addr     = wr_base + addr_t'(wr_off);
    wr_byte     = bus.in_data;
    wr_off_nxt  = wr_off;
    wr_base_nxt = wr_base;
    wr_done     = 1'b0;
    drop_inc    = 1'b0;
    hec_clr     = 1'b0;
    hec_step    = 1'b0;
    if (acc) begin
      if (bus.in_soc) begin
        drop_inc   = (wr_off != '0);
        wr_en      = 1'b1;
        wr_addr    = wr_base;
        wr_off_nxt = 6'd1;
        hec_clr    = 1'b1;
        hec_step   = 1'b1;
      end else if (wr_off == '0) begin
        drop_inc = 1'b1;
      end else begin
        wr_en      = 1'b1;
        wr_off_nxt = wr_off + 6'd1;
        hec_step   = (wr_off < HEC_OFF);
        if (GEN_HEC && wr_off == HEC_OFF) wr_byte = hec ^ HEC_COSET;
        if (wr_off == LAST_OFF) begin
          wr_off_nxt  = '0;
          wr_base_nxt = next_base(wr_base);
          wr_done     = 1'b1;
        end
      end
    end
  end

  // Read side: outputs only move on edges with en low
  always_comb begin
    state_nxt   = state;
    rd_off_nxt  = rd_off;
    rd_base_nxt = rd_base;
    rd_load     = 1'b0;
    rd_rel      = 1'b0;
    soc_nxt     = soc_q;
    rd_addr     = rd_base + addr_t'(rd_off) + addr_t'(1);
    if (!bus.en) begin
      case (state)
        IDLE: begin
          if (cell_cnt != '0) begin
            rd_load    = 1'b1;
            soc_nxt    = 1'b1;
            rd_off_nxt = '0;
            rd_addr    = rd_base;
            state_nxt  = SEND;
          end else begin
            soc_nxt = 1'b0;
          end
        end
        SEND, PAUSE: begin
          if (rd_off == LAST_OFF) begin
            rd_rel      = 1'b1;
            rd_base_nxt = next_base(rd_base);
            rd_off_nxt  = '0;
            soc_nxt     = 1'b0;
            state_nxt   = IDLE;
            // A cell completed on this same edge is not yet eligible.
            if (cell_cnt > ONE_C) begin
              rd_load   = 1'b1;
              soc_nxt   = 1'b1;
              rd_addr   = next_base(rd_base);
              state_nxt = SEND;
            end
          end else begin
            rd_load    = 1'b1;
            soc_nxt    = 1'b0;
            rd_off_nxt = rd_off + 6'd1;
            state_nxt  = SEND;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end else if (state == SEND) begin
      state_nxt = PAUSE;
    end
  end

  always_comb begin
    cnt_nxt = cell_cnt;
    if (wr_done && !rd_rel)      cnt_nxt = cell_cnt + ONE_C;
    else if (!wr_done && rd_rel) cnt_nxt = cell_cnt - ONE_C;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rd_off  <= '0;
      rd_base <= '0;
    end else begin
      state   <= state_nxt;
      rd_off  <= rd_off_nxt;
      rd_base <= rd_base_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_off     <= '0;
      wr_base    <= '0;
      cell_cnt   <= '0;
      drop_cnt   <= 8'h00;
      soc_q      <= 1'b0;
      clav_q     <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      wr_off     <= wr_off_nxt;
      wr_base    <= wr_base_nxt;
      cell_cnt   <= cnt_nxt;
      soc_q      <= soc_nxt;
      clav_q     <= (cnt_nxt != '0);
      in_ready_q <= (cnt_nxt < DEPTH_C);
      if (drop_inc && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'h01;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_byte;
  end

  always_ff @(posedge clk) begin
    if (rst)          data_q <= 8'h00;
    else if (rd_load) data_q <= mem[rd_addr];
  end
endmodule

// File: tb/tb_utopia1_phy_tx.sv
// Directed bench: HEC-inserting DEPTH=2 instance plus a pass-through twin on identical stimulus.
module tb_utopia1_phy_tx;
  typedef logic [52:0][7:0] cell_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  initial forever #5 clk = ~clk;

  utopia1_phy_tx_if bus ();
  utopia1_phy_tx_if raw ();
  logic [1:0] cnt_a, cnt_b;
  logic [7:0] drop_a, drop_b;

  utopia1_phy_tx #(.DEPTH(2), .GEN_HEC(1'b1)) u_dut (
    .clk(clk), .rst(rst), .bus(bus), .cell_cnt(cnt_a), .drop_cnt(drop_a));
  utopia1_phy_tx #(.DEPTH(2), .GEN_HEC(1'b0)) u_raw (
    .clk(clk), .rst(rst), .bus(raw), .cell_cnt(cnt_b), .drop_cnt(drop_b));

  logic [8:0] src_q [$];
  int n_chk  = 0;
  int n_fail = 0;

  function automatic cell_t mk(input logic [7:0] h3, input logic [7:0] b4, input logic [7:0] p0);
    cell_t c;
    c    = '0;
    c[3] = h3;
    c[4] = b4;
    for (int i = 0; i < 48; i++) c[5+i] = p0 + 8'(i);
    return c;
  endfunction

  task automatic check(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[%0d]: got %0h, want %0h", tag, idx, obs, exp);
    end
  endtask

  task automatic push_bytes(input cell_t c, input int n);
    for (int i = 0; i < n; i++) src_q.push_back({1'(i == 0), c[i]});
  endtask

  // One clock: present head of source queue and en, then sample #1 after the edge
  task automatic cyc(input logic en_v);
    logic acc;
    bus.en = en_v;
    raw.en = en_v;
    if (src_q.size() > 0) begin
      bus.in_valid = 1'b1;
      bus.in_soc   = src_q[0][8];
      bus.in_data  = src_q[0][7:0];
    end else begin
      bus.in_valid = 1'b0;
      bus.in_soc   = 1'b0;
      bus.in_data  = 8'h00;
    end
    raw.in_valid = bus.in_valid;
    raw.in_soc   = bus.in_soc;
    raw.in_data  = bus.in_data;
    acc = bus.in_valid && bus.in_ready;
    @(posedge clk);
    #1;
    if (acc) void'(src_q.pop_front());
  endtask

  task automatic load();
    int n;
    n = 0;
    while (src_q.size() > 0 && n < 400) begin
      cyc(1'b1);
      n++;
    end
    check("load_done", n, src_q.size(), 0);
  endtask

  task automatic read_part(input cell_t c, input cell_t r, input int first, input int last, input bit chk_raw);
    for (int k = first; k <= last; k++) begin
      cyc(1'b0);
      check("data", k, bus.data, c[k]);
      check("soc", k, bus.soc, (k == 0));
      if (chk_raw) check("raw_data", k, raw.data, r[k]);
    end
  endtask

  initial begin
    cell_t e1, e2, e3;
    bus.en = 1'b1; raw.en = 1'b1;
    bus.in_valid = 1'b0; raw.in_valid = 1'b0;
    bus.in_soc = 1'b0; raw.in_soc = 1'b0;
    bus.in_data = 8'h00; raw.in_data = 8'h00;

    // reset state
    cyc(1'b1); cyc(1'b1);
    check("rst_data", 0, bus.data, 8'h00);
    check("rst_soc", 0, bus.soc, 1'b0);
    check("rst_clav", 0, bus.clav, 1'b0);
    check("rst_ready", 0, bus.in_ready, 1'b0);
    check("rst_cnt", 0, cnt_a, 2'd0);
    check("rst_drop", 0, drop_a, 8'h00);
    rst = 1'b0;
    cyc(1'b1);
    check("ready_after_rst", 0, bus.in_ready, 1'b1);

    // single cell, HEC of 00 00 00 01 is 8'h52
    push_bytes(mk(8'h01, 8'hA5, 8'h00), 53);
    load();
    check("t1_clav", 0, bus.clav, 1'b1);
    check("t1_cnt", 0, cnt_a, 2'd1);
    e1 = mk(8'h01, 8'h52, 8'h00);
    read_part(e1, e1, 0, 52, 1'b0);
    check("t1_clav_last", 0, bus.clav, 1'b1);
    cyc(1'b0);
    check("t1_clav_end", 0, bus.clav, 1'b0);
    check("t1_cnt_end", 0, cnt_a, 2'd0);

    // zero header -> coset only; pass-through twin keeps byte 4
    push_bytes(mk(8'h00, 8'hA5, 8'h10), 53);
    load();
    read_part(mk(8'h00, 8'h55, 8'h10), mk(8'h00, 8'hA5, 8'h10), 0, 52, 1'b1);
    cyc(1'b0);

    // two cells back to back
    push_bytes(mk(8'h01, 8'h11, 8'h20), 53);
    push_bytes(mk(8'h00, 8'h22, 8'h40), 53);
    load();
    check("t3_cnt", 0, cnt_a, 2'd2);
    check("t3_raw_cnt", 0, cnt_b, 2'd2);
    check("t3_ready_full", 0, bus.in_ready, 1'b0);
    read_part(mk(8'h01, 8'h52, 8'h20), e1, 0, 52, 1'b0);
    read_part(mk(8'h00, 8'h55, 8'h40), e1, 0, 52, 1'b0);
    cyc(1'b0);
    check("t3_clav_end", 0, bus.clav, 1'b0);
    check("t3_cnt_end", 0, cnt_a, 2'd0);

    // en pause at byte 20
    push_bytes(mk(8'h01, 8'h00, 8'h60), 53);
    load();
    e1 = mk(8'h01, 8'h52, 8'h60);
    read_part(e1, e1, 0, 20, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1);
      check("t4_hold", i, bus.data, e1[20]);
      check("t4_hold_soc", i, bus.soc, 1'b0);
      check("t4_hold_clav", i, bus.clav, 1'b1);
    end
    read_part(e1, e1, 21, 52, 1'b0);
    cyc(1'b0);
    check("t4_clav_end", 0, bus.clav, 1'b0);

    // full buffer, third cell loads as first drains; completes on second's release edge
    push_bytes(mk(8'h01, 8'h00, 8'h80), 53);
    push_bytes(mk(8'h00, 8'h00, 8'hA0), 53);
    load();
    check("t5_ready_full", 0, bus.in_ready, 1'b0);
    push_bytes(mk(8'h01, 8'h00, 8'hC0), 53);
    e1 = mk(8'h01, 8'h52, 8'h80);
    e2 = mk(8'h00, 8'h55, 8'hA0);
    e3 = mk(8'h01, 8'h52, 8'hC0);
    read_part(e1, e1, 0, 52, 1'b0);
    check("t5_ready_b52", 0, bus.in_ready, 1'b0);
    check("t5_src_b52", 0, src_q.size(), 53);
    read_part(e2, e2, 0, 0, 1'b0);
    check("t5_ready_free", 0, bus.in_ready, 1'b1);
    read_part(e2, e2, 1, 52, 1'b0);
    cyc(1'b0);
    check("t5_cnt_simul", 0, cnt_a, 2'd1);
    check("t5_clav_simul", 0, bus.clav, 1'b1);
    check("t5_soc_gap", 0, bus.soc, 1'b0);
    check("t5_data_gap", 0, bus.data, e2[52]);
    check("t5_src_empty", 0, src_q.size(), 0);
    read_part(e3, e3, 0, 52, 1'b0);
    cyc(1'b0);
    check("t5_clav_end", 0, bus.clav, 1'b0);
    check("t5_cnt_end", 0, cnt_a, 2'd0);

    // framing errors: restart at offset 30, then stray non-soc byte
    push_bytes(mk(8'h01, 8'h00, 8'h00), 30);
    push_bytes(mk(8'h01, 8'h00, 8'hE0), 53);
    src_q.push_back({1'b0, 8'h77});
    push_bytes(mk(8'h00, 8'h00, 8'hF0), 53);
    load();
    check("t6_drop", 0, drop_a, 8'd2);
    check("t6_raw_drop", 0, drop_b, 8'd2);
    check("t6_cnt", 0, cnt_a, 2'd2);
    read_part(mk(8'h01, 8'h52, 8'hE0), e1, 0, 52, 1'b0);
    read_part(mk(8'h00, 8'h55, 8'hF0), e1, 0, 52, 1'b0);
    cyc(1'b0);
    check("t6_clav_end", 0, bus.clav, 1'b0);

    // reset mid-send with a partial write in flight
    push_bytes(mk(8'h01, 8'h00, 8'h33), 53);
    load();
    push_bytes(mk(8'h00, 8'h00, 8'h99), 20);
    read_part(mk(8'h01, 8'h52, 8'h33), e1, 0, 10, 1'b0);
    src_q.delete();
    rst = 1'b1;
    cyc(1'b0);
    check("t7_data", 0, bus.data, 8'h00);
    check("t7_soc", 0, bus.soc, 1'b0);
    check("t7_clav", 0, bus.clav, 1'b0);
    check("t7_ready", 0, bus.in_ready, 1'b0);
    check("t7_cnt", 0, cnt_a, 2'd0);
    check("t7_drop", 0, drop_a, 8'h00);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1'b0);
    check("t7_idle_clav", 0, bus.clav, 1'b0);
    check("t7_idle_soc", 0, bus.soc, 1'b0);
    check("t7_idle_data", 0, bus.data, 8'h00);
    push_bytes(mk(8'h00, 8'h00, 8'h44), 53);
    load();
    e1 = mk(8'h00, 8'h55, 8'h44);
    read_part(e1, e1, 0, 52, 1'b0);
    cyc(1'b0);
    check("t7_clav_end", 0, bus.clav, 1'b0);
    check("t7_drop_end", 0, drop_a, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
